// File: rtl/mem_access_ctrl_if.sv
// Bundle of the MEM-stage request/response handshake and the data RAM port.
// master = load/store controller side, slave = pipeline + RAM side.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              stall_req;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              exc_misaligned;
   logic [ADDR_W-1:0] exc_badvaddr;
   logic              mem_ce;
   logic              mem_we;
   logic [3:0]        mem_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport master (
      input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
      output req_ready, stall_req, resp_valid, resp_rdata, exc_misaligned, exc_badvaddr,
      output mem_ce, mem_we, mem_sel, mem_addr, mem_wdata
   );

   modport slave (
      output req_valid, req_op, req_addr, req_wdata, mem_rdata,
      input  req_ready, stall_req, resp_valid, resp_rdata, exc_misaligned, exc_badvaddr,
      input  mem_ce, mem_we, mem_sel, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store initiator for a big-endian data RAM port (IDLE -> ACCESS -> RESP).
// Define UNALIGNED_EXC_EN to trap unaligned halfword/word accesses instead of issuing them.
module mem_access_ctrl #(
   parameter int MEM_LATENCY = 1,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   mem_access_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic [2:0]        op_q;
   logic [1:0]        off_q;
   logic              mem_ce_q;
   logic              mem_we_q;
   logic [3:0]        mem_sel_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;
   logic              resp_valid_q;
   logic [31:0]       resp_rdata_q;
   logic              exc_q;
   logic [ADDR_W-1:0] badvaddr_q;

   function automatic logic is_store(input logic [2:0] op);
      return op >= 3'b101;
   endfunction

   // Lane 3 carries byte offset 0 (big-endian).
   function automatic logic [3:0] lane_sel(input logic [2:0] op, input logic [1:0] off);
      case (op)
         3'b000, 3'b001, 3'b101: lane_sel = 4'b1000 >> off;
         3'b010, 3'b011, 3'b110: lane_sel = off[1] ? 4'b0011 : 4'b1100;
         default:                lane_sel = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [2:0] op, input logic [31:0] wd);
      case (op)
         3'b101:  lane_wdata = {4{wd[7:0]}};
         3'b110:  lane_wdata = {2{wd[15:0]}};
         3'b111:  lane_wdata = wd;
         default: lane_wdata = 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = rd[31:24];
         2'd1:    b = rd[23:16];
         2'd2:    b = rd[15:8];
         default: b = rd[7:0];
      endcase
      h = off[1] ? rd[15:0] : rd[31:16];
      case (op)
         3'b000:  load_extend = 32'($signed(b));
         3'b001:  load_extend = {24'd0, b};
         3'b010:  load_extend = 32'($signed(h));
         3'b011:  load_extend = {16'd0, h};
         3'b100:  load_extend = rd;
         default: load_extend = 32'd0;
      endcase
   endfunction

`ifdef UNALIGNED_EXC_EN
   function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
      case (op)
         3'b010, 3'b011, 3'b110: misaligned = off[0];
         3'b100, 3'b111:         misaligned = |off;
         default:                misaligned = 1'b0;
      endcase
   endfunction
`endif

   assign bus.req_ready      = (state_q == IDLE);
   assign bus.stall_req      = ((state_q == IDLE) && bus.req_valid) || (state_q == ACCESS);
   assign bus.mem_ce         = mem_ce_q;
   assign bus.mem_we         = mem_we_q;
   assign bus.mem_sel        = mem_sel_q;
   assign bus.mem_addr       = mem_addr_q;
   assign bus.mem_wdata      = mem_wdata_q;
   assign bus.resp_valid     = resp_valid_q;
   assign bus.resp_rdata     = resp_rdata_q;
   assign bus.exc_misaligned = exc_q;
   assign bus.exc_badvaddr   = badvaddr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         op_q         <= 3'd0;
         off_q        <= 2'd0;
         mem_ce_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_sel_q    <= 4'd0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         exc_q        <= 1'b0;
         badvaddr_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  op_q  <= bus.req_op;
                  off_q <= bus.req_addr[1:0];
`ifdef UNALIGNED_EXC_EN
                  if (misaligned(bus.req_op, bus.req_addr[1:0])) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= 32'd0;
                     exc_q        <= 1'b1;
                     badvaddr_q   <= bus.req_addr;
                  end else
`endif
                  begin
                     // A single-cycle access writes on its only cycle.
                     state_q     <= ACCESS;
                     cnt_q       <= LAT_LAST;
                     mem_ce_q    <= 1'b1;
                     mem_we_q    <= is_store(bus.req_op) && (LAT_LAST == 4'd0);
                     mem_sel_q   <= lane_sel(bus.req_op, bus.req_addr[1:0]);
                     mem_addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                     mem_wdata_q <= lane_wdata(bus.req_op, bus.req_wdata);
                  end
               end
            end
            ACCESS: begin
               if (cnt_q == 4'd0) begin
                  state_q      <= RESP;
                  mem_ce_q     <= 1'b0;
                  mem_we_q     <= 1'b0;
                  mem_sel_q    <= 4'd0;
                  mem_addr_q   <= '0;
                  mem_wdata_q  <= 32'd0;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= is_store(op_q) ? 32'd0 : load_extend(op_q, off_q, bus.mem_rdata);
                  exc_q        <= 1'b0;
               end else begin
                  cnt_q    <= cnt_q - 4'd1;
                  mem_we_q <= is_store(op_q) && (cnt_q == 4'd1);
               end
            end
            RESP: begin
               state_q      <= IDLE;
               resp_valid_q <= 1'b0;
               resp_rdata_q <= 32'd0;
               exc_q        <= 1'b0;
               badvaddr_q   <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: byte-addressed reference memory model plus
// per-cycle output comparison, with pinned directed cases and randomized traffic.
module tb_mem_access_ctrl;
   localparam int LAT = 3;
   localparam logic [2:0] OP_LB = 3'd0, OP_LBU = 3'd1, OP_LH = 3'd2, OP_LHU = 3'd3,
                          OP_LW = 3'd4, OP_SB = 3'd5, OP_SH = 3'd6, OP_SW = 3'd7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_access_ctrl_if #(.ADDR_W(32)) bus ();
   mem_access_ctrl #(.MEM_LATENCY(LAT), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 37 + 11) % 256);
   endfunction

   function automatic logic [31:0] init_word(input int k);
      return {init_byte(4*k), init_byte(4*k+1), init_byte(4*k+2), init_byte(4*k+3)};
   endfunction

   function automatic int op_size(input logic [2:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1;
         OP_LH, OP_LHU, OP_SH: return 2;
         default:              return 4;
      endcase
   endfunction

   function automatic logic op_store(input logic [2:0] op);
      return op >= OP_SB;
   endfunction

   function automatic int op_start(input logic [2:0] op, input logic [31:0] addr);
      case (op_size(op))
         1:       return int'(addr[1:0]);
         2:       return addr[1] ? 2 : 0;
         default: return 0;
      endcase
   endfunction

   function automatic logic op_misaligned(input logic [2:0] op, input logic [31:0] addr);
`ifdef UNALIGNED_EXC_EN
      return (op_size(op) == 2 && addr[0]) || (op_size(op) == 4 && addr[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int ref_base(input logic [2:0] op, input logic [31:0] addr);
      return int'({addr[7:2], 2'b00}) + op_start(op, addr);
   endfunction

   function automatic logic [3:0] exp_sel(input logic [2:0] op, input logic [31:0] addr);
      int sz = op_size(op);
      int st = op_start(op, addr);
      return 4'(((1 << sz) - 1) << (4 - st - sz));
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] wd);
      case (op_size(op))
         1:       return 32'(wd[7:0]) * 32'h0101_0101;
         2:       return 32'(wd[15:0]) * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   // Reference memory: one entry per byte, offset 0 is the most significant byte of a word.
   logic [7:0]  ref_mem [256];
   bit          m_init = 1'b0;
   bit          m_pend = 1'b0;
   bit          m_exc  = 1'b0;
   int          m_ph   = 0;
   logic [2:0]  m_op   = 3'd0;
   logic [31:0] m_addr = 32'd0;
   logic [31:0] m_wd   = 32'd0;

   function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
      logic [31:0] v = 32'd0;
      int sz = op_size(op);
      int b  = ref_base(op, addr);
      for (int i = 0; i < sz; i++) v = (v << 8) | 32'(ref_mem[b + i]);
      if ((op == OP_LB || op == OP_LH) && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
      return v;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (!m_init) begin
         for (int i = 0; i < 256; i++) ref_mem[i] <= init_byte(i);
         m_init <= 1'b1;
      end
      if (rst) begin
         m_pend <= 1'b0;
         m_ph   <= 0;
      end else if (m_pend) begin
         if (m_ph >= (m_exc ? 1 : LAT + 1)) m_pend <= 1'b0;
         else begin
            if (m_ph == LAT && op_store(m_op) && !m_exc)
               for (int i = 0; i < op_size(m_op); i++)
                  ref_mem[ref_base(m_op, m_addr) + i] <= 8'(m_wd >> (8 * (op_size(m_op) - 1 - i)));
            m_ph <= m_ph + 1;
         end
      end else if (bus.req_valid) begin
         m_pend <= 1'b1;
         m_ph   <= 1;
         m_op   <= bus.req_op;
         m_addr <= bus.req_addr;
         m_wd   <= bus.req_wdata;
         m_exc  <= op_misaligned(bus.req_op, bus.req_addr);
      end
   end

   logic c_acc, c_rsp;
   assign c_acc = m_pend && !m_exc && m_ph <= LAT;
   assign c_rsp = m_pend && (m_ph == (m_exc ? 1 : LAT + 1));

   // Data RAM seen by the DUT.
   logic [31:0] ram [64];
   bit          r_init = 1'b0;
   always @(posedge clk) begin
      if (!r_init) begin
         for (int k = 0; k < 64; k++) ram[k] <= init_word(k);
         r_init <= 1'b1;
      end else if (bus.mem_ce && bus.mem_we) begin
         for (int j = 0; j < 4; j++)
            if (bus.mem_sel[3-j]) ram[bus.mem_addr[7:2]][31-8*j -: 8] <= bus.mem_wdata[31-8*j -: 8];
      end
   end
   assign bus.mem_rdata = ram[bus.mem_addr[7:2]];

   always @(negedge clk) begin
      if (m_init) begin
         chk("req_ready", 32'(bus.req_ready), 32'(!m_pend));
         chk("stall_req", 32'(bus.stall_req), 32'((!m_pend && bus.req_valid) || c_acc));
         chk("mem_ce", 32'(bus.mem_ce), 32'(c_acc));
         chk("mem_we", 32'(bus.mem_we), 32'(c_acc && op_store(m_op) && m_ph == LAT));
         chk("mem_sel", 32'(bus.mem_sel), c_acc ? 32'(exp_sel(m_op, m_addr)) : 32'd0);
         chk("mem_addr", bus.mem_addr, c_acc ? {m_addr[31:2], 2'b00} : 32'd0);
         if (!c_acc) chk("mem_wdata_idle", bus.mem_wdata, 32'd0);
         else if (op_store(m_op)) chk("mem_wdata", bus.mem_wdata, exp_wdata(m_op, m_wd));
         chk("resp_valid", 32'(bus.resp_valid), 32'(c_rsp));
         if (c_rsp) begin
            chk("resp_rdata", bus.resp_rdata,
                (m_exc || op_store(m_op)) ? 32'd0 : ref_load(m_op, m_addr));
            chk("exc_misaligned", 32'(bus.exc_misaligned), 32'(m_exc));
            chk("exc_badvaddr", bus.exc_badvaddr, m_exc ? m_addr : 32'd0);
         end
      end
   end

   logic        t_got, t_exc;
   int          t_stall, t_we, t_ce, t_lat;
   logic [3:0]  t_sel;
   logic [31:0] t_wd, t_rd, t_bad;

   task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
      t_got = 1'b0; t_exc = 1'b0; t_stall = 0; t_we = 0; t_ce = 0; t_lat = -1;
      t_sel = 4'd0; t_wd = 32'd0; t_rd = 32'd0; t_bad = 32'd0;
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wd;
      for (int n = 0; n < 24 && !t_got; n++) begin
         @(negedge clk);
         if (bus.stall_req) t_stall++;
         if (bus.mem_we) t_we++;
         if (bus.mem_ce) begin
            t_ce++;
            t_sel = bus.mem_sel;
            t_wd  = bus.mem_wdata;
         end
         if (bus.resp_valid) begin
            t_got = 1'b1; t_lat = n; t_rd = bus.resp_rdata;
            t_exc = bus.exc_misaligned; t_bad = bus.exc_badvaddr;
         end else begin
            @(posedge clk); #1;
            bus.req_valid = 1'($urandom); bus.req_op = 3'($urandom);
            bus.req_addr = $urandom; bus.req_wdata = $urandom;
         end
      end
      chk("resp_seen", 32'(t_got), 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  r_op;
      logic [31:0] r_addr;
      bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_stall", 32'(bus.stall_req), 32'd0);
      chk("rst_mem_ce", 32'(bus.mem_ce), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
      chk("rst_exc", 32'(bus.exc_misaligned), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      rst = 1'b0;

      issue(OP_SW, 32'h10, 32'hDEAD_BEEF);
      chk("sw_sel", 32'(t_sel), 32'hF);
      chk("sw_wdata", t_wd, 32'hDEAD_BEEF);
      chk("sw_we_cycles", t_we, 1);
      chk("sw_latency", t_lat, 4);
      issue(OP_LW, 32'h10, 32'h0);
      chk("lw_rdata", t_rd, 32'hDEAD_BEEF);
      chk("lw_latency", t_lat, 4);
      chk("lw_stall_cycles", t_stall, 4);
      chk("lw_we_cycles", t_we, 0);
      chk("lw_ce_cycles", t_ce, 3);

      issue(OP_LW, 32'h11, 32'h0);
`ifdef UNALIGNED_EXC_EN
      chk("unal_exc", 32'(t_exc), 32'd1);
      chk("unal_badvaddr", t_bad, 32'h11);
      chk("unal_ce_cycles", t_ce, 0);
      chk("unal_rdata", t_rd, 32'd0);
      chk("unal_latency", t_lat, 1);
`else
      chk("unal_exc", 32'(t_exc), 32'd0);
      chk("unal_rdata", t_rd, 32'hDEAD_BEEF);
`endif

      issue(OP_SB, 32'h13, 32'h0000_00A5);
      chk("sb_sel", 32'(t_sel), 32'h1);
      chk("sb_wdata", t_wd, 32'hA5A5_A5A5);
      issue(OP_LB, 32'h13, 32'h0);
      chk("lb_rdata", t_rd, 32'hFFFF_FFA5);
      issue(OP_LBU, 32'h13, 32'h0);
      chk("lbu_rdata", t_rd, 32'h0000_00A5);

      issue(OP_SH, 32'h12, 32'h0000_8001);
      chk("sh_sel", 32'(t_sel), 32'h3);
      chk("sh_wdata", t_wd, 32'h8001_8001);
      issue(OP_LH, 32'h12, 32'h0);
      chk("lh_rdata", t_rd, 32'hFFFF_8001);
      issue(OP_LHU, 32'h12, 32'h0);
      chk("lhu_rdata", t_rd, 32'h0000_8001);

      // Reset lands in the write cycle of a store.
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_op = OP_SW; bus.req_addr = 32'h20; bus.req_wdata = 32'h1234_5678;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("abort_we_before", 32'(bus.mem_we), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("abort_mem_ce", 32'(bus.mem_ce), 32'd0);
      chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
      chk("abort_mem_sel", 32'(bus.mem_sel), 32'd0);
      chk("abort_mem_addr", bus.mem_addr, 32'd0);
      chk("abort_mem_wdata", bus.mem_wdata, 32'd0);
      chk("abort_stall", 32'(bus.stall_req), 32'd0);
      chk("abort_ready", 32'(bus.req_ready), 32'd1);
      repeat (LAT + 2) @(posedge clk);
      #1 rst = 1'b0;
      chk("abort_word", ram[8], init_word(8));
      issue(OP_LW, 32'h20, 32'h0);
      chk("abort_next_rdata", t_rd, init_word(8));
      chk("abort_next_latency", t_lat, 4);

      for (int k = 0; k < 160; k++) begin
         r_op   = 3'($urandom);
         r_addr = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (op_size(r_op) == 2) r_addr[0] = 1'b0;
            if (op_size(r_op) == 4) r_addr[1:0] = 2'b00;
         end
         issue(r_op, r_addr, $urandom);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      @(posedge clk); #1;
      for (int k = 0; k < 64; k++)
         chk("ram_final", ram[k], {ref_mem[4*k], ref_mem[4*k+1], ref_mem[4*k+2], ref_mem[4*k+3]});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
